// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for the MIPS pipeline.
// Owns the PC, drives the instruction-memory address and captures the returned
// word into the IF/ID register. Handles stall, flush, branch and jump redirects,
// and stops on a HALT word.
// Optional feature macro: FETCH_TRAP_EN. When it is defined, a misaligned redirect
// target sets a sticky fault and halts. When it is not defined, the two low target
// bits are cleared instead.
module fetch_ctrl #(
   parameter int                ADDR_W    = 7,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [DATA_W-1:0] NOP_WORD  = 32'h00000000,
   parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFFFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   input  logic              flush,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   output logic [ADDR_W-1:0] add,
   input  logic [DATA_W-1:0] instruc,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc4,
   output logic              ifid_valid,
   output logic [1:0]        state,
   output logic              fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_STALL = 2'b10,
      S_HALT  = 2'b11
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] redir_tgt;
   logic              redirect;

   // Clear the two low bits so that a redirect always lands on a word boundary.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(3);
   endfunction

   // The PC wraps modulo 2^ADDR_W. No carry flag is produced.
   assign pc_plus4  = pc + ADDR_W'(4);
   assign redirect  = jump | branch_taken;
   assign redir_tgt = jump ? jump_target : branch_target;
   assign add       = pc;
   assign state     = state_q;

`ifdef FETCH_TRAP_EN
   logic fault_q;
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   // Sequencer: PC, IF/ID register and state, arbitrated by redirect/flush/stall priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc         <= RESET_PC;
         ifid_instr <= NOP_WORD;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
`ifdef FETCH_TRAP_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) state_q <= S_RUN;
            end
            S_RUN, S_STALL: begin
               if (redirect) begin
                  ifid_instr <= NOP_WORD;
                  ifid_valid <= 1'b0;
`ifdef FETCH_TRAP_EN
                  if (redir_tgt[1:0] != 2'b00) begin
                     fault_q <= 1'b1;
                     state_q <= S_HALT;
                  end else begin
                     pc      <= redir_tgt;
                     state_q <= S_RUN;
                  end
`else
                  pc      <= word_align(redir_tgt);
                  state_q <= S_RUN;
`endif
               end else if (flush) begin
                  ifid_instr <= NOP_WORD;
                  ifid_valid <= 1'b0;
                  state_q    <= S_RUN;
               end else if (stall) begin
                  state_q <= S_STALL;
               end else begin
                  ifid_instr <= instruc;
                  ifid_pc4   <= pc_plus4;
                  ifid_valid <= 1'b1;
                  if (instruc == HALT_WORD) begin
                     state_q <= S_HALT;
                  end else begin
                     pc      <= pc_plus4;
                     state_q <= S_RUN;
                  end
               end
            end
            default: begin
               // HALT: the PC is frozen and bubbles drain through IF/ID until reset.
               ifid_instr <= NOP_WORD;
               ifid_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed test of the fetch_ctrl sequencer with a combinational
// instruction memory model.
module tb_fetch_ctrl;

   localparam logic [31:0] NOP  = 32'h00000000;
   localparam logic [31:0] HALT = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stall, flush, branch_taken, jump;
   logic [6:0]  branch_target, jump_target;
   logic [6:0]  add;
   logic [31:0] instruc;
   logic [31:0] ifid_instr;
   logic [6:0]  ifid_pc4;
   logic        ifid_valid;
   logic [1:0]  state;
   logic        fault;

   logic [31:0] mem [0:31];
   int          errors = 0;
   int          checks = 0;

   fetch_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .add           (add),
      .instruc       (instruc),
      .ifid_instr    (ifid_instr),
      .ifid_pc4      (ifid_pc4),
      .ifid_valid    (ifid_valid),
      .state         (state),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   assign instruc = mem[add[6:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | i;
      rst = 1'b1; start = 0; stall = 0; flush = 0;
      branch_taken = 0; jump = 0; branch_target = '0; jump_target = '0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("rst_add", add, 0);
      chk("rst_state", state, 0);
      chk("rst_valid", ifid_valid, 0);
      chk("rst_instr", ifid_instr, NOP);
      chk("rst_pc4", ifid_pc4, 0);
      chk("rst_fault", fault, 0);
      tick();
      chk("idle_hold_state", state, 0);
      chk("idle_hold_add", add, 0);

      // T1 sequential fetch
      start = 1; tick(); start = 0;
      chk("t1_run", state, 1);
      chk("t1_add0", add, 7'h00);
      tick();
      chk("t1_add1", add, 7'h04);
      chk("t1_pc4_1", ifid_pc4, 7'h04);
      chk("t1_instr1", ifid_instr, 32'hA000_0000);
      chk("t1_valid1", ifid_valid, 1);
      tick();
      chk("t1_add2", add, 7'h08);
      chk("t1_pc4_2", ifid_pc4, 7'h08);
      chk("t1_instr2", ifid_instr, 32'hA000_0001);

      // T2 stall for two cycles at pc 0x08
      stall = 1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("t2_add", add, 7'h08);
         chk("t2_state", state, 2);
         chk("t2_pc4", ifid_pc4, 7'h08);
         chk("t2_instr", ifid_instr, 32'hA000_0001);
      end
      stall = 0; tick();
      chk("t2_rel_add", add, 7'h0C);
      chk("t2_rel_state", state, 1);
      chk("t2_rel_pc4", ifid_pc4, 7'h0C);
      chk("t2_rel_instr", ifid_instr, 32'hA000_0002);

      // T3 branch to 0x14 at pc 0x0C
      branch_taken = 1; branch_target = 7'h14; tick(); branch_taken = 0;
      chk("t3_br_add", add, 7'h14);
      chk("t3_br_valid", ifid_valid, 0);
      chk("t3_br_instr", ifid_instr, NOP);
      tick();
      chk("t3_after_add", add, 7'h18);
      chk("t3_after_valid", ifid_valid, 1);
      chk("t3_after_instr", ifid_instr, 32'hA000_0005);
      // jump beats branch, and a redirect beats stall
      branch_taken = 1; branch_target = 7'h14; jump = 1; jump_target = 7'h20; stall = 1;
      tick();
      branch_taken = 0; jump = 0; stall = 0;
      chk("t3_jmp_add", add, 7'h20);
      chk("t3_jmp_valid", ifid_valid, 0);
      chk("t3_jmp_state", state, 1);

      // flush: refetch the same pc
      flush = 1; tick(); flush = 0;
      chk("flush_add", add, 7'h20);
      chk("flush_valid", ifid_valid, 0);
      chk("flush_state", state, 1);
      tick();
      chk("flush_refetch_add", add, 7'h24);
      chk("flush_refetch_instr", ifid_instr, 32'hA000_0008);

      // T4 wrap from 0x7C
      jump = 1; jump_target = 7'h7C; tick(); jump = 0;
      chk("t4_add7c", add, 7'h7C);
      tick();
      chk("t4_wrap_add", add, 7'h00);
      chk("t4_wrap_pc4", ifid_pc4, 7'h00);
      chk("t4_wrap_instr", ifid_instr, 32'hA000_001F);

      // T5 HALT word at 0x10
      mem[4] = HALT;
      jump = 1; jump_target = 7'h10; tick(); jump = 0;
      chk("t5_add10", add, 7'h10);
      tick();
      chk("t5_halt_instr", ifid_instr, HALT);
      chk("t5_halt_valid", ifid_valid, 1);
      chk("t5_halt_state", state, 3);
      chk("t5_halt_add", add, 7'h10);
      // inputs are ignored in HALT
      jump = 1; jump_target = 7'h20; start = 1; tick();
      jump = 0; start = 0;
      chk("t5_drain_valid", ifid_valid, 0);
      chk("t5_drain_instr", ifid_instr, NOP);
      chk("t5_hold_add", add, 7'h10);
      chk("t5_hold_state", state, 3);
      // asynchronous reset mid-cycle
      #3 rst = 1; #1;
      chk("t5_arst_add", add, 7'h00);
      chk("t5_arst_state", state, 0);
      chk("t5_arst_valid", ifid_valid, 0);
      tick(); rst = 0;
      mem[4] = 32'hA000_0004;

      // T6 misaligned branch target 0x15
      start = 1; tick(); start = 0;
      branch_taken = 1; branch_target = 7'h15; tick(); branch_taken = 0;
`ifdef FETCH_TRAP_EN
      chk("t6_fault", fault, 1);
      chk("t6_state", state, 3);
      chk("t6_add", add, 7'h00);
`else
      chk("t6_add", add, 7'h14);
      chk("t6_fault", fault, 0);
      chk("t6_state", state, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
